dual_issue_scheduler: RTL and testbench

//  Pairing controller for the dual-issue backend; sits between decode and the issue buffers.
//  - Each cycle, decides whether the decoded pair issues together, issues split over two cycles, or is held.
//  - Drives the per-lane special-stall/kill signals that the pipeline register logic consumes.
//  - Also generates the load-use interlock against the execute stage.

---
 rtl/dual_issue_scheduler_if.sv | 44 ++++
 rtl/dual_issue_scheduler.sv | 107 ++++++++++
 tb/tb_dual_issue_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dual_issue_scheduler_if.sv
// Decode-to-scheduler bundle: decoded pair, execute-stage load info, issue/stall decisions.
// Perf counter outputs exist only when SCHED_PERF_CNT_EN is defined.
interface dual_issue_scheduler_if #(
  parameter int CNT_W = 32
);
  logic       backend_we_i;
  logic       flush_i;
  logic       valid0_i, valid1_i;
  logic [4:0] rd0_i, rd1_i;
  logic       rdwe0_i, rdwe1_i;
  logic [4:0] rs1_0_i, rs2_0_i, rs1_1_i, rs2_1_i;
  logic       use1_0_i, use2_0_i, use1_1_i, use2_1_i;
  logic       mem0_i, mem1_i;
  logic       br0_i, br1_i;
  logic       ex_load_i;
  logic [4:0] ex_rd_i;
  logic       issue_en0_o, issue_en1_o;
  logic       issue0_stall_o, issue1_stall_o;
  logic       hold_dec_o;
  logic       load_use_o;
`ifdef SCHED_PERF_CNT_EN
  logic [CNT_W-1:0] perf_dual_o, perf_split_o, perf_lu_o;
`endif

  modport master (
    output backend_we_i, flush_i, valid0_i, valid1_i, rd0_i, rd1_i, rdwe0_i, rdwe1_i,
           rs1_0_i, rs2_0_i, rs1_1_i, rs2_1_i, use1_0_i, use2_0_i, use1_1_i, use2_1_i,
           mem0_i, mem1_i, br0_i, br1_i, ex_load_i, ex_rd_i,
    input  issue_en0_o, issue_en1_o, issue0_stall_o, issue1_stall_o, hold_dec_o, load_use_o
`ifdef SCHED_PERF_CNT_EN
    , input perf_dual_o, perf_split_o, perf_lu_o
`endif
  );

  modport slave (
    input  backend_we_i, flush_i, valid0_i, valid1_i, rd0_i, rd1_i, rdwe0_i, rdwe1_i,
           rs1_0_i, rs2_0_i, rs1_1_i, rs2_1_i, use1_0_i, use2_0_i, use1_1_i, use2_1_i,
           mem0_i, mem1_i, br0_i, br1_i, ex_load_i, ex_rd_i,
    output issue_en0_o, issue_en1_o, issue0_stall_o, issue1_stall_o, hold_dec_o, load_use_o
`ifdef SCHED_PERF_CNT_EN
    , output perf_dual_o, perf_split_o, perf_lu_o
`endif
  );
endinterface

// File: rtl/dual_issue_scheduler.sv
// Dual-issue pairing controller: same-cycle pair/split/hold decision plus load-use interlock.
// Optional SCHED_PERF_CNT_EN adds wrapping dual/split/load-use counters.
module dual_issue_scheduler #(
  parameter int CNT_W       = 32,
  parameter bit DUAL_BRANCH = 1'b0
) (
  input logic               clock_i,
  input logic               reset_n_i,
  dual_issue_scheduler_if.slave bus
);
  localparam logic [0:0] ST_PAIR       = 1'b0;
  localparam logic [0:0] ST_SLOT1_PEND = 1'b1;

  logic [0:0] state_q, state_d;
  logic       raw, hazard, lu_s0, lu_s1, lu;
  logic       en0, en1, st0, st1, hold, lu_out;

  function automatic logic ex_match(input logic use_src, input logic [4:0] rs,
                                    input logic ex_load, input logic [4:0] ex_rd);
    return ex_load & (ex_rd != 5'd0) & use_src & (rs == ex_rd);
  endfunction

  // x0 is filtered by the rd0 != 0 term, so a write to x0 never forces a split.
  assign raw = bus.rdwe0_i & (bus.rd0_i != 5'd0) & bus.valid0_i &
               ((bus.use1_1_i & (bus.rs1_1_i == bus.rd0_i)) |
                (bus.use2_1_i & (bus.rs2_1_i == bus.rd0_i)));
  assign hazard = (bus.mem0_i & bus.mem1_i) | (!DUAL_BRANCH & bus.br0_i & bus.br1_i) | raw;

  assign lu_s0 = bus.valid0_i &
                 (ex_match(bus.use1_0_i, bus.rs1_0_i, bus.ex_load_i, bus.ex_rd_i) |
                  ex_match(bus.use2_0_i, bus.rs2_0_i, bus.ex_load_i, bus.ex_rd_i));
  assign lu_s1 = bus.valid1_i &
                 (ex_match(bus.use1_1_i, bus.rs1_1_i, bus.ex_load_i, bus.ex_rd_i) |
                  ex_match(bus.use2_1_i, bus.rs2_1_i, bus.ex_load_i, bus.ex_rd_i));
  // Once slot 0 has issued only slot 1's sources are still waiting.
  assign lu = (state_q == ST_PAIR) ? (lu_s0 | lu_s1) : lu_s1;

  always_comb begin
    state_d = state_q;
    en0     = 1'b0;
    en1     = 1'b0;
    st0     = 1'b0;
    st1     = 1'b0;
    hold    = 1'b0;
    lu_out  = 1'b0;
    if (!reset_n_i || bus.flush_i) begin
      state_d = ST_PAIR;
    end else if (state_q == ST_PAIR) begin
      if (lu) begin
        lu_out = 1'b1;
        hold   = 1'b1;
      end else if (bus.valid0_i && bus.valid1_i && hazard) begin
        en0  = 1'b1;
        st0  = 1'b1;
        hold = 1'b1;
        if (bus.backend_we_i) state_d = ST_SLOT1_PEND;
      end else begin
        en0 = bus.valid0_i;
        en1 = bus.valid1_i;
      end
    end else begin
      if (lu) begin
        lu_out = 1'b1;
        hold   = 1'b1;
      end else begin
        en1 = 1'b1;
        st1 = 1'b1;
        if (bus.backend_we_i) state_d = ST_PAIR;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) state_q <= ST_PAIR;
    else            state_q <= state_d;
  end

  assign bus.issue_en0_o    = en0;
  assign bus.issue_en1_o    = en1;
  assign bus.issue0_stall_o = st0;
  assign bus.issue1_stall_o = st1;
  assign bus.hold_dec_o     = hold;
  assign bus.load_use_o     = lu_out;

`ifdef SCHED_PERF_CNT_EN
  logic [CNT_W-1:0] dual_cnt, split_cnt, lu_cnt;

  // Outputs are already zero under flush, so flush never bumps a counter.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      dual_cnt  <= '0;
      split_cnt <= '0;
      lu_cnt    <= '0;
    end else if (bus.backend_we_i) begin
      if (en0 && en1) dual_cnt <= dual_cnt + CNT_W'(1);
      if (st0)        split_cnt <= split_cnt + CNT_W'(1);
      if (lu_out)     lu_cnt <= lu_cnt + CNT_W'(1);
    end
  end

  assign bus.perf_dual_o  = dual_cnt;
  assign bus.perf_split_o = split_cnt;
  assign bus.perf_lu_o    = lu_cnt;
`else
  localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler with an expected-output scoreboard.
module tb_dual_issue_scheduler;
  localparam int TB_CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  string      tag_q[$];
  logic [5:0] exp_q[$];

  dual_issue_scheduler_if #(.CNT_W(TB_CNT_W)) bus ();

  dual_issue_scheduler #(.CNT_W(TB_CNT_W), .DUAL_BRANCH(1'b0)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.backend_we_i = 1'b1; bus.flush_i = 1'b0;
    bus.valid0_i = 1'b0; bus.valid1_i = 1'b0;
    bus.rd0_i = 5'd0; bus.rd1_i = 5'd0; bus.rdwe0_i = 1'b0; bus.rdwe1_i = 1'b0;
    bus.rs1_0_i = 5'd0; bus.rs2_0_i = 5'd0; bus.rs1_1_i = 5'd0; bus.rs2_1_i = 5'd0;
    bus.use1_0_i = 1'b0; bus.use2_0_i = 1'b0; bus.use1_1_i = 1'b0; bus.use2_1_i = 1'b0;
    bus.mem0_i = 1'b0; bus.mem1_i = 1'b0; bus.br0_i = 1'b0; bus.br1_i = 1'b0;
    bus.ex_load_i = 1'b0; bus.ex_rd_i = 5'd0;
  endtask

  // Two ALU ops, both write rd and read both sources.
  task automatic set_pair(input logic [4:0] d0, s10, s20, d1, s11, s21);
    bus.valid0_i = 1'b1; bus.valid1_i = 1'b1;
    bus.rd0_i = d0; bus.rs1_0_i = s10; bus.rs2_0_i = s20;
    bus.rd1_i = d1; bus.rs1_1_i = s11; bus.rs2_1_i = s21;
    bus.rdwe0_i = 1'b1; bus.rdwe1_i = 1'b1;
    bus.use1_0_i = 1'b1; bus.use2_0_i = 1'b1; bus.use1_1_i = 1'b1; bus.use2_1_i = 1'b1;
    bus.mem0_i = 1'b0; bus.mem1_i = 1'b0; bus.br0_i = 1'b0; bus.br1_i = 1'b0;
  endtask

  // Expected vector: {issue_en0, issue_en1, issue0_stall, issue1_stall, hold_dec, load_use}
  task automatic apply(input string tag, input logic [5:0] exp);
    logic [5:0] got;
    logic [5:0] want;
    string      t;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    @(negedge clk);
    got  = {bus.issue_en0_o, bus.issue_en1_o, bus.issue0_stall_o,
            bus.issue1_stall_o, bus.hold_dec_o, bus.load_use_o};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", t, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] DUAL  = 6'b110000;
  localparam logic [5:0] SPL0  = 6'b101010;
  localparam logic [5:0] SPL1  = 6'b010100;
  localparam logic [5:0] LU    = 6'b000011;
  localparam logic [5:0] IDLE  = 6'b000000;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    set_pair(5'd5, 5'd1, 5'd2, 5'd7, 5'd5, 5'd1);
    apply("reset_outputs_zero", IDLE);
    rst_n = 1'b1;

    set_pair(5'd3, 5'd1, 5'd2, 5'd6, 5'd4, 5'd5);
    apply("indep_dual", DUAL);

    set_pair(5'd5, 5'd1, 5'd2, 5'd7, 5'd5, 5'd1);
    apply("raw_split_c0", SPL0);
    apply("raw_split_c1", SPL1);
    set_pair(5'd3, 5'd1, 5'd2, 5'd6, 5'd4, 5'd5);
    apply("raw_split_back_pair", DUAL);

    set_pair(5'd3, 5'd1, 5'd2, 5'd6, 5'd4, 5'd5);
    bus.mem0_i = 1'b1; bus.mem1_i = 1'b1; bus.backend_we_i = 1'b0;
    for (int i = 0; i < 3; i++) apply("mem_stalled_stays_pair", SPL0);
    bus.backend_we_i = 1'b1;
    apply("mem_advance_c0", SPL0);
    apply("mem_advance_c1", SPL1);

    set_pair(5'd3, 5'd9, 5'd2, 5'd6, 5'd4, 5'd5);
    bus.ex_load_i = 1'b1; bus.ex_rd_i = 5'd9;
    apply("load_use_slot0", LU);
    bus.ex_load_i = 1'b0;
    apply("load_use_release", DUAL);

    set_pair(5'd3, 5'd1, 5'd2, 5'd6, 5'd4, 5'd5);
    bus.ex_load_i = 1'b1; bus.ex_rd_i = 5'd0; bus.rs1_0_i = 5'd0;
    apply("ex_rd_x0_no_lu", DUAL);
    bus.ex_load_i = 1'b0;

    set_pair(5'd0, 5'd1, 5'd2, 5'd6, 5'd0, 5'd4);
    apply("rd0_x0_no_split", DUAL);
    set_pair(5'd4, 5'd1, 5'd2, 5'd4, 5'd3, 5'd5);
    apply("waw_no_split", DUAL);
    set_pair(5'd3, 5'd1, 5'd2, 5'd6, 5'd4, 5'd5);
    bus.valid0_i = 1'b0;
    apply("slot1_only", 6'b010000);
    bus.valid0_i = 1'b1;
    apply("slot1_only_then_pair", DUAL);

    set_pair(5'd0, 5'd1, 5'd2, 5'd0, 5'd4, 5'd5);
    bus.br0_i = 1'b1; bus.br1_i = 1'b1;
    apply("dual_branch_split_c0", SPL0);
    apply("dual_branch_split_c1", SPL1);

    set_pair(5'd5, 5'd1, 5'd2, 5'd7, 5'd5, 5'd1);
    apply("pend_lu_setup", SPL0);
    bus.ex_load_i = 1'b1; bus.ex_rd_i = 5'd1;
    apply("pend_lu_slot1", LU);
    bus.ex_rd_i = 5'd2;
    apply("pend_lu_ignores_slot0", SPL1);
    bus.ex_load_i = 1'b0;

    set_pair(5'd5, 5'd1, 5'd2, 5'd7, 5'd5, 5'd1);
    apply("flush_setup", SPL0);
    bus.flush_i = 1'b1;
    apply("flush_in_pend", IDLE);
    bus.flush_i = 1'b0;
    apply("flush_back_to_pair", SPL0);

    rst_n = 1'b0;
    apply("reset_mid_split", IDLE);
    rst_n = 1'b1;
    set_pair(5'd3, 5'd1, 5'd2, 5'd6, 5'd4, 5'd5);
    apply("reset_back_to_pair", DUAL);

`ifdef SCHED_PERF_CNT_EN
    rst_n = 1'b0;
    apply("perf_reset", IDLE);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) apply("perf_dual_issue", DUAL);
    clear_inputs();
    @(negedge clk);
    vectors++;
    assert (bus.perf_dual_o === 4'd1) else begin
      miscompares++;
      $error("FAIL perf_dual_wrap observed=%0d expected=1", bus.perf_dual_o);
    end
    vectors++;
    assert (bus.perf_split_o === 4'd0) else begin
      miscompares++;
      $error("FAIL perf_split_zero observed=%0d expected=0", bus.perf_split_o);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
